// File: rtl/branch_flag_ctrl.sv
// Branch resolution and NZCV flag ownership for the pipelined LEGv8 core.
// Optional macro FLAG_FWD_EN: resolve B.cond from the in-flight ALU flags instead of stalling.
module branch_flag_ctrl #(
    parameter int WIDTH        = 64,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_neg,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             set_flags,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] cbz_val,
    output logic             take_branch,
    output logic             flush,
    output logic             stall,
    output logic [3:0]       flags
);

    // state     | meaning
    // IDLE      | waiting for a branch in ID
    // FLAG_WAIT | B.cond stalled one cycle for the flag write in EX
    // FLUSH     | taken branch, holding flush for FLUSH_CYCLES cycles
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLAG_WAIT = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] cond_q, cond_d;
    logic       take_d, flush_d, stall_d;
    logic [3:0] alu_flags;
    logic [3:0] eval_flags;
    logic       hazard_stall;
    logic       br_taken;

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_true = z;
            4'h1:    cond_true = !z;
            4'h2:    cond_true = cy;
            4'h3:    cond_true = !cy;
            4'h4:    cond_true = n;
            4'h5:    cond_true = !n;
            4'h6:    cond_true = v;
            4'h7:    cond_true = !v;
            4'h8:    cond_true = cy && !z;
            4'h9:    cond_true = !cy || z;
            4'hA:    cond_true = (n == v);
            4'hB:    cond_true = (n != v);
            4'hC:    cond_true = !z && (n == v);
            4'hD:    cond_true = z || (n != v);
            default: cond_true = 1'b1;
        endcase
    endfunction

    assign alu_flags = {alu_neg, ~|alu_result, alu_carry, alu_ovf};

`ifdef FLAG_FWD_EN
    // Flags being written this cycle are forwarded straight into the B.cond decision.
    assign eval_flags   = set_flags ? alu_flags : flags;
    assign hazard_stall = 1'b0;
    assign stall        = 1'b0;
`else
    assign eval_flags   = flags;
    assign hazard_stall = br_valid && (br_type == 2'b11) && set_flags;
    assign stall        = stall_d && !reset;
`endif

    always_comb begin
        case (br_type)
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = (cbz_val == '0);
            2'b10:   br_taken = (cbz_val != '0);
            default: br_taken = cond_true(cond, eval_flags);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cond_d  = cond_q;
        take_d  = 1'b0;
        flush_d = 1'b0;
        stall_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    if (hazard_stall) begin
                        stall_d = 1'b1;
                        cond_d  = cond;
                        state_d = FLAG_WAIT;
                    end else if (br_taken) begin
                        take_d  = 1'b1;
                        flush_d = 1'b1;
                        cnt_d   = FLUSH_LOAD;
                        state_d = FLUSH;
                    end
                end
            end
            FLAG_WAIT: begin
                if (cond_true(cond_q, flags)) begin
                    take_d  = 1'b1;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            cond_q      <= 4'h0;
            take_branch <= 1'b0;
            flush       <= 1'b0;
            flags       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cond_q      <= cond_d;
            take_branch <= take_d;
            flush       <= flush_d;
            if (set_flags) begin
                flags <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Bench for branch_flag_ctrl: directed scenarios, then random traffic against an event-schedule model.
module tb_branch_flag_ctrl;

    localparam int WIDTH = 64;
    localparam int FC    = 3;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] alu_result;
    logic             alu_neg, alu_carry, alu_ovf, set_flags, br_valid;
    logic [1:0]       br_type;
    logic [3:0]       cond;
    logic [WIDTH-1:0] cbz_val;
    logic             take_branch, flush, stall;
    logic [3:0]       flags;

    branch_flag_ctrl #(.WIDTH(WIDTH), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .alu_neg(alu_neg),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf), .set_flags(set_flags),
        .br_valid(br_valid), .br_type(br_type), .cond(cond), .cbz_val(cbz_val),
        .take_branch(take_branch), .flush(flush), .stall(stall), .flags(flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: edge-indexed schedule of when take/flush are high and when ID is ignored.
    int       ecnt = 0;
    int       busy_thru = -1, tb_edge = -1, fl_lo = -1, fl_hi = -2;
    bit       pending = 1'b0;
    bit [3:0] pcond = 4'h0;
    bit [3:0] m_flags = 4'h0;
    bit       exp_take = 1'b0, exp_flush = 1'b0;
    bit       chk_en = 1'b0;

    // ARM encoding: cond[3:1] picks a base test, cond[0] inverts it (except AL).
    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c[0] && c[3:1] != 3'd7) ? ~base : base;
    endfunction

    task automatic schedule(input int e);
        tb_edge   = e;
        fl_lo     = e;
        fl_hi     = e + FC - 1;
        busy_thru = e + FC;
    endtask

    task automatic model_step();
        bit [3:0] nf;
        bit tk;
        int e;
        e = ecnt;
        ecnt++;
        if (reset) begin
            m_flags = 4'h0; pending = 1'b0; busy_thru = -1;
            tb_edge = -1; fl_lo = -1; fl_hi = -2;
        end else begin
            nf = {alu_neg, alu_result == 0, alu_carry, alu_ovf};
            if (pending) begin
                pending = 1'b0;
                if (cond_ok(pcond, m_flags)) schedule(e);
            end else if (e > busy_thru && br_valid) begin
                if (br_type == 2'd3 && set_flags && !FWD) begin
                    pending = 1'b1;
                    pcond   = cond;
                end else begin
                    case (br_type)
                        2'd0: tk = 1'b1;
                        2'd1: tk = (cbz_val == 0);
                        2'd2: tk = (cbz_val != 0);
                        default: tk = cond_ok(cond, set_flags ? nf : m_flags);
                    endcase
                    if (tk) schedule(e);
                end
            end
            if (set_flags) m_flags = nf;
        end
        exp_take  = (tb_edge == e);
        exp_flush = (e >= fl_lo) && (e <= fl_hi);
    endtask

    function automatic bit exp_stall();
        return !reset && !FWD && !pending && (ecnt > busy_thru) &&
               br_valid && br_type == 2'd3 && set_flags;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("take_branch", {3'b0, take_branch}, {3'b0, exp_take});
            chk("flush", {3'b0, flush}, {3'b0, exp_flush});
            chk("flags", flags, m_flags);
            chk("stall", {3'b0, stall}, {3'b0, exp_stall()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic drive(input bit v, input bit [1:0] t, input bit [3:0] c, input bit [WIDTH-1:0] cz);
        br_valid = v; br_type = t; cond = c; cbz_val = cz;
    endtask

    task automatic alu(input bit sf, input bit [WIDTH-1:0] r, input bit n, input bit cy, input bit v);
        set_flags = sf; alu_result = r; alu_neg = n; alu_carry = cy; alu_ovf = v;
    endtask

    task automatic idle(input int k);
        drive(0, 0, 0, 0);
        for (int i = 0; i < k; i++) cyc();
    endtask

    initial begin
        reset = 1'b1;
        alu(0, 64'd1, 0, 0, 0);
        drive(1, 2'b00, 4'h0, 64'd1);
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_flags", flags, 4'b0000);
        chk("rst_take", {3'b0, take_branch}, 4'h0);
        chk("rst_flush", {3'b0, flush}, 4'h0);
        chk("rst_stall", {3'b0, stall}, 4'h0);

        reset = 1'b0;
        cyc();
        chk("b_take", {3'b0, take_branch}, 4'h1);
        chk("b_flush", {3'b0, flush}, 4'h1);
        cyc();
        chk("flush2_take", {3'b0, take_branch}, 4'h0);
        chk("flush2", {3'b0, flush}, 4'h1);
        cyc();
        chk("flush3", {3'b0, flush}, 4'h1);
        drive(0, 0, 0, 0);
        cyc();
        chk("flush_end", {3'b0, flush}, 4'h0);

        alu(1, 64'd0, 0, 1, 0);
        cyc();
        chk("flags_0110", flags, 4'b0110);
        chk("model_0110", m_flags, 4'b0110);
        alu(0, 64'd7, 0, 0, 0);
        drive(1, 2'b11, 4'h0, 0);
        cyc();
        chk("eq_taken", {3'b0, take_branch}, 4'h1);
        idle(3);
        drive(1, 2'b11, 4'h8, 0);
        cyc();
        chk("hi_not_taken", {3'b0, take_branch | flush}, 4'h0);

        drive(1, 2'b01, 0, 64'h0);
        cyc();
        chk("cbz_zero", {3'b0, take_branch}, 4'h1);
        idle(3);
        drive(1, 2'b10, 0, 64'h8000_0000_0000_0000);
        cyc();
        chk("cbnz_msb", {3'b0, take_branch}, 4'h1);
        idle(3);
        drive(1, 2'b01, 0, 64'h8000_0000_0000_0000);
        cyc();
        chk("cbz_msb", {3'b0, take_branch}, 4'h0);

        drive(1, 2'b11, 4'hB, 0);
        alu(1, 64'd5, 1, 0, 0);
        #1;
        chk("haz_stall", {3'b0, stall}, {3'b0, !FWD});
        cyc();
        alu(0, 64'd5, 0, 0, 0);
        #1;
        chk("haz_stall_drop", {3'b0, stall}, 4'h0);
        chk("haz_take1", {3'b0, take_branch}, {3'b0, FWD});
        cyc();
        chk("haz_take2", {3'b0, take_branch}, {3'b0, !FWD});
        idle(4);

        drive(1, 2'b11, 4'hE, 0);
        alu(1, 64'd0, 1, 1, 1);
        cyc();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        alu(0, 64'd1, 0, 0, 0);
        cyc();
        chk("rst_fw_take", {3'b0, take_branch}, 4'h0);
        chk("rst_fw_flush", {3'b0, flush}, 4'h0);
        chk("rst_fw_flags", flags, 4'b0000);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            br_valid = ($urandom_range(0, 1) == 1);
            br_type  = 2'($urandom_range(0, 3));
            cond     = 4'($urandom_range(0, 15));
            cbz_val  = ($urandom_range(0, 2) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            set_flags = ($urandom_range(0, 4) < 2);
            alu_result = ($urandom_range(0, 2) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            alu_neg   = 1'($urandom);
            alu_carry = 1'($urandom);
            alu_ovf   = 1'($urandom);
            cyc();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_flag_ctrl.md
Name: branch_flag_ctrl

Overview:
Sequences conditional control flow in the pipelined ARM (LEGv8) core.
- Owns the architectural NZCV flag register, loaded from the EX-stage ALU on flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves B, CBZ, CBNZ and B.cond.
- Drives the fetch redirect, the IF/ID flush and a one-cycle stall when B.cond depends on a flag update still in EX.

Parameters:
WIDTH, 64, datapath width of alu_result and cbz_val
FLUSH_CYCLES, 1, cycles flush is held after a taken branch (1..3)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
alu_result  in  WIDTH  EX-stage ALU result
alu_neg  in  1  EX ALU negative flag
alu_carry  in  1  EX ALU carry flag
alu_ovf  in  1  EX ALU overflow flag
set_flags  in  1  EX instruction writes NZCV this cycle
br_valid  in  1  ID stage holds a branch
br_type  in  2  00 B, 01 CBZ, 10 CBNZ, 11 B.cond
cond  in  4  ARM condition code for B.cond
cbz_val  in  WIDTH  forwarded register operand for CBZ/CBNZ
take_branch  out  1  registered, one-cycle pulse: redirect PC to branch target
flush  out  1  registered, squash IF/ID
stall  out  1  combinational, hold PC and IF/ID
flags  out  4  registered NZCV, {N,Z,C,V}

Behaviour:
- Reset (sync, high): flags=4'b0000, take_branch=0, flush=0, state=IDLE, flush counter=0. stall=0 while reset is high. Reset mid-FLAG_WAIT or mid-FLUSH aborts it; no pulse follows.
- Flag register: at posedge with set_flags=1, flags <= {alu_neg, ~|alu_result, alu_carry, alu_ovf}. Zero is a full-width reduction of alu_result. Otherwise flags hold. Flag updates continue in every state.
- Condition eval, using ARM semantics on NZCV:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E, F always
- Taken decision: B always; CBZ iff cbz_val==0; CBNZ iff cbz_val!=0; B.cond iff cond evaluates true.
- FSM states:
  - IDLE:
    - br_valid=0: stay.
    - Hazard = br_valid & br_type==11 & set_flags. On hazard: stall=1 this cycle, latch cond, go to FLAG_WAIT.
    - Any other branch: resolve against current flags/cbz_val. If taken: take_branch<=1, flush<=1, go to FLUSH. If not taken: stay, outputs 0.
  - FLAG_WAIT (exactly 1 cycle):
    - stall=0; br_valid ignored, since ID still holds the same stalled branch.
    - Evaluate the latched cond against the registered flags (now updated).
    - If taken: take_branch<=1, flush<=1, go to FLUSH. Else go to IDLE.
  - FLUSH:
    - flush stays 1 for FLUSH_CYCLES cycles total; take_branch drops after the first.
    - br_valid ignored, because the branch is in a squashed slot.
    - Return to IDLE when the counter expires.
- Latency: non-hazard branch sampled at edge T gives take_branch/flush high in cycle T+1. Hazard adds exactly 1 cycle.
- Simultaneous events: set_flags with a B/CBZ/CBNZ causes no stall (no flag dependency). set_flags during FLUSH still updates flags.
- CBZ/CBNZ never stall; operand hazards are the forwarding unit's job.

Optional Feature:
FLAG_FWD_EN
- Defined: no stall. In the hazard cycle, B.cond is resolved in IDLE using the incoming ALU flags {alu_neg, ~|alu_result, alu_carry, alu_ovf} instead of the flags register. FLAG_WAIT is unreachable and stall is tied 0.
- Undefined: stall/FLAG_WAIT behaviour as above.

Test Plan:
- Reset held 2 cycles with br_valid=1, br_type=00 -> flags=0000, take_branch=0, flush=0, stall=0; first cycle after reset with B -> take_branch=1, flush=1 next cycle.
- set_flags=1, alu_result=0, alu_carry=1 -> flags=0110. Next cycle B.cond cond=0 (EQ) -> taken. cond=8 (HI) -> not taken, FSM stays IDLE.
- CBZ cbz_val=64'h0 -> taken; CBNZ cbz_val=64'h8000_0000_0000_0000 -> taken; CBZ with the same value -> not taken.
- B.cond cond=B (LT) in same cycle as set_flags with alu_neg=1, alu_ovf=0. Without FLAG_FWD_EN: stall=1 for one cycle, take_branch one cycle later. With FLAG_FWD_EN: stall stays 0, take_branch next cycle.
- FLUSH_CYCLES=3 with a taken B -> flush high 3 cycles, take_branch high 1 cycle; br_valid=1 during FLUSH ignored.
- Reset asserted in the FLAG_WAIT cycle -> next cycle take_branch=0, flush=0, state IDLE, flags=0000.
